// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: scans a 28x28 pixel frame as 576 overlapping 5x5
// windows (row-major origins) and presents each one to the CNN core.
// The first window of every row is loaded with 25 reads. Every later
// window in the row reuses 20 bytes by shifting left and reading 1 new column.
// Optional build macro SEQ_STALL_COUNT_EN adds the STALL_CNT output.
module conv_window_sequencer (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         START,
   output logic         BUSY,
   output logic         MEM_RD,
   output logic [9:0]   MEM_ADDR,
   input  logic [7:0]   MEM_DATA,
   output logic         WIN_VALID,
   input  logic         WIN_READY,
   output logic [199:0] WIN,
   output logic [4:0]   WIN_X,
   output logic [4:0]   WIN_Y,
   output logic         WIN_LAST,
   output logic         FRAME_DONE
`ifdef SEQ_STALL_COUNT_EN
   ,
   output logic [15:0]  STALL_CNT
`endif
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FILL    = 3'd1;
   localparam logic [2:0] SHIFT   = 3'd2;
   localparam logic [2:0] PRESENT = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]        state;
   logic [4:0]        x, y;          // window origin (row, column)
   logic [2:0]        ri, cj;        // offset of the read currently on the bus
   logic              rd;
   logic [9:0]        addr;
   logic              pend;          // read issued last cycle, data on MEM_DATA now
   logic [4:0]        pend_idx;      // window byte that data belongs to
   logic [24:0][7:0]  win;
   logic [2:0]        nxt_ri, nxt_cj;
   logic              last_rd, hs;

   function automatic logic [9:0] pix_addr(input logic [4:0] ox, input logic [4:0] oy,
                                           input logic [2:0] i, input logic [2:0] j);
      logic [9:0] row, col;
      row = 10'(ox) + 10'(i);
      col = 10'(oy) + 10'(j);
      return row * 10'd28 + col;
   endfunction

   // Next read offset: FILL walks all 25 bytes row-major, SHIFT walks column 4 only
   always_comb begin
      nxt_ri  = ri;
      nxt_cj  = cj;
      last_rd = (ri == 3'd4) && (cj == 3'd4);
      if (state == SHIFT) begin
         nxt_ri = ri + 3'd1;
         nxt_cj = 3'd4;
      end else if (cj == 3'd4) begin
         nxt_ri = ri + 3'd1;
         nxt_cj = 3'd0;
      end else begin
         nxt_cj = cj + 3'd1;
      end
      hs = (state == PRESENT) && WIN_READY;
   end

   // Control FSM, scan position and read-strobe/address generation
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         ri    <= '0;
         cj    <= '0;
         rd    <= 1'b0;
         addr  <= '0;
      end else begin
         case (state)
            IDLE: if (START) begin
               state <= FILL;
               x     <= '0;
               y     <= '0;
               ri    <= '0;
               cj    <= '0;
               rd    <= 1'b1;
               addr  <= pix_addr(5'd0, 5'd0, 3'd0, 3'd0);
            end
            FILL, SHIFT: begin
               if (rd) begin
                  if (last_rd) rd <= 1'b0;
                  else begin
                     ri   <= nxt_ri;
                     cj   <= nxt_cj;
                     addr <= pix_addr(x, y, nxt_ri, nxt_cj);
                  end
               end else if (pend) begin
                  // last byte lands this edge, so the window is complete next cycle
                  state <= PRESENT;
               end
            end
            PRESENT: if (WIN_READY) begin
               if (y != 5'd23) begin
                  state <= SHIFT;
                  y     <= y + 5'd1;
                  ri    <= '0;
                  cj    <= 3'd4;
                  rd    <= 1'b1;
                  addr  <= pix_addr(x, y + 5'd1, 3'd0, 3'd4);
               end else if (x != 5'd23) begin
                  state <= FILL;
                  x     <= x + 5'd1;
                  y     <= '0;
                  ri    <= '0;
                  cj    <= '0;
                  rd    <= 1'b1;
                  addr  <= pix_addr(x + 5'd1, 5'd0, 3'd0, 3'd0);
               end else begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Window register: capture returning read data, or shift left one column on handshake
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pend     <= 1'b0;
         pend_idx <= '0;
         win      <= '0;
      end else begin
         pend     <= rd;
         pend_idx <= {2'b00, ri} * 5'd5 + {2'b00, cj};
         if (pend) begin
            win[pend_idx] <= MEM_DATA;
         end else if (hs) begin
            for (int i = 0; i < 5; i++)
               for (int j = 0; j < 4; j++)
                  win[i*5+j] <= win[i*5+j+1];
         end
      end
   end

`ifdef SEQ_STALL_COUNT_EN
   logic [15:0] stall;

   // Saturating count of cycles the core holds off a presented window
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                                                stall <= '0;
      else if (state == IDLE && START)                          stall <= '0;
      else if (state == PRESENT && !WIN_READY && stall != 16'hFFFF) stall <= stall + 16'd1;
   end

   assign STALL_CNT = stall;
`endif

   assign BUSY       = (state != IDLE);
   assign MEM_RD     = rd;
   assign MEM_ADDR   = addr;
   assign WIN_VALID  = (state == PRESENT);
   assign WIN        = win;
   assign WIN_X      = x;
   assign WIN_Y      = y;
   assign WIN_LAST   = (state == PRESENT) && (x == 5'd23) && (y == 5'd23);
   assign FRAME_DONE = (state == DONE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: a frame model (window n -> origin n/24, n%24,
// bytes taken straight from the pixel array) checked every cycle, plus literal
// cycle/byte expectations for a ramp frame. Honours SEQ_STALL_COUNT_EN.
module tb_conv_window_sequencer;
   logic         CLK = 1'b0, nRST = 1'b0, START = 1'b0, WIN_READY = 1'b1;
   logic         BUSY, MEM_RD, WIN_VALID, WIN_LAST, FRAME_DONE;
   logic [9:0]   MEM_ADDR;
   logic [7:0]   MEM_DATA = 8'd0;
   logic [199:0] WIN;
   logic [4:0]   WIN_X, WIN_Y;
`ifdef SEQ_STALL_COUNT_EN
   logic [15:0]  STALL_CNT;
`endif

   conv_window_sequencer dut (
      .CLK(CLK), .nRST(nRST), .START(START), .BUSY(BUSY), .MEM_RD(MEM_RD),
      .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .WIN_VALID(WIN_VALID),
      .WIN_READY(WIN_READY), .WIN(WIN), .WIN_X(WIN_X), .WIN_Y(WIN_Y),
      .WIN_LAST(WIN_LAST), .FRAME_DONE(FRAME_DONE)
`ifdef SEQ_STALL_COUNT_EN
      , .STALL_CNT(STALL_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   logic [7:0]   mem [0:783];
   int           nvec = 0, nfail = 0;
   int           ecnt = 0, acc = 0;
   int           n = 0, mstall = 0, rdy_mode = 0;
   int           win_rel [0:575];
   int           done_rel = -1, rd_first = -1, rd_cnt1 = 0;
   logic         prev_done = 1'b0;
   logic [199:0] w0, w1;

   // synchronous pixel memory: data valid the cycle after the strobe
   always @(posedge CLK) if (MEM_RD && MEM_ADDR < 10'd784) MEM_DATA <= mem[MEM_ADDR];
   always @(posedge CLK) ecnt <= ecnt + 1;

   // random READY driver
   always @(posedge CLK) begin
      #2;
      if (rdy_mode == 1) WIN_READY = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // frame model compare, every cycle
   always @(negedge CLK) begin
      int rel, ex, ey, mm, a;
      rel = ecnt - acc + 1;
      if (!nRST) begin
         n = 0; mstall = 0; prev_done = 1'b0;
      end else begin
         if (MEM_RD) begin
            chk("rd_busy", BUSY, 1);
            chk("rd_addr_range", MEM_ADDR < 10'd784, 1);
            if (rel <= 26) begin
               if (rd_first < 0) rd_first = rel;
               rd_cnt1++;
            end
         end
         if (WIN_VALID) begin
            chk("valid_busy", BUSY, 1);
            chk("valid_no_rd", MEM_RD, 0);
            if (n >= 576) chk("extra_window", n, 575);
            else begin
               ex = n / 24; ey = n % 24;
               if (win_rel[n] < 0) win_rel[n] = rel;
               if (n == 0) w0 = WIN;
               if (n == 1) w1 = WIN;
               chk("win_x", WIN_X, ex);
               chk("win_y", WIN_Y, ey);
               chk("win_last", WIN_LAST, n == 575);
               mm = 0;
               for (int k = 0; k < 25; k++) begin
                  a = (ex + k / 5) * 28 + ey + k % 5;
                  if (WIN[k*8 +: 8] !== mem[a]) begin mm = k; break; end
               end
               a = (ex + mm / 5) * 28 + ey + mm % 5;
               chk($sformatf("win_byte%0d_w%0d", mm, n), WIN[mm*8 +: 8], mem[a]);
               if (WIN_READY) n++;
            end
         end
         if (FRAME_DONE) begin
            chk("done_count", n, 576);
            chk("done_single", prev_done, 0);
            chk("done_busy", BUSY, 1);
            if (done_rel < 0) done_rel = rel;
            n = 0;
         end
         prev_done = FRAME_DONE;
`ifdef SEQ_STALL_COUNT_EN
         chk("stall_cnt", STALL_CNT, mstall);
         if (!BUSY && START) mstall = 0;
         else if (WIN_VALID && !WIN_READY && mstall < 65535) mstall++;
`endif
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic start_frame();
      for (int i = 0; i < 576; i++) win_rel[i] = -1;
      done_rel = -1; rd_first = -1; rd_cnt1 = 0;
      START = 1'b1;
      @(posedge CLK); #1;
      acc = ecnt;
      START = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         @(negedge CLK);
         if (FRAME_DONE) break;
      end
      if (c >= budget) chk("done_timeout", 0, 1);
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, BUSY, 0);
      chk({tag, "_rd"}, MEM_RD, 0);
      chk({tag, "_addr"}, MEM_ADDR, 0);
      chk({tag, "_valid"}, WIN_VALID, 0);
      chk({tag, "_win_nz"}, |WIN, 0);
      chk({tag, "_x"}, WIN_X, 0);
      chk({tag, "_y"}, WIN_Y, 0);
      chk({tag, "_last"}, WIN_LAST, 0);
      chk({tag, "_done"}, FRAME_DONE, 0);
`ifdef SEQ_STALL_COUNT_EN
      chk({tag, "_stall"}, STALL_CNT, 0);
`endif
   endtask

   task automatic rand_mem();
      for (int i = 0; i < 784; i++) mem[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int c;
      for (int i = 0; i < 784; i++) mem[i] = 8'(i % 256);
      for (int i = 0; i < 576; i++) win_rel[i] = -1;
      #12;
      chk_zero("reset");
      tick(); nRST = 1'b1; tick(); tick();

      // ramp frame, READY always high: literal timing and bytes
      start_frame();
      wait_done(6000);
      chk("f1_rd_first", rd_first, 1);
      chk("f1_rd_count", rd_cnt1, 25);
      chk("f1_w00_cycle", win_rel[0], 27);
      chk("f1_w01_cycle", win_rel[1], 34);
      chk("f1_w10_cycle", win_rel[24], 215);
      chk("f1_w2323_cycle", win_rel[575], 4512);
      chk("f1_done_cycle", done_rel, 4513);
      chk("f1_w00_b0", w0[0 +: 8], 8'h00);
      chk("f1_w00_b4", w0[32 +: 8], 8'h04);
      chk("f1_w00_b5", w0[40 +: 8], 8'h1C);
      chk("f1_w00_b24", w0[192 +: 8], 8'h74);
      chk("f1_w01_b0", w1[0 +: 8], 8'h01);
      chk("f1_w01_b24", w1[192 +: 8], 8'h75);
      tick();
      chk("f1_idle_after_done", BUSY, 0);

      // random pixels, window (0,0) stalled 10 cycles, then random READY
      rand_mem();
      WIN_READY = 1'b0;
      start_frame();
      for (c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (WIN_VALID) break;
      end
      chk("f2_first_valid", c < 100, 1);
      repeat (10) @(posedge CLK);
      #1;
      chk("f2_hold_valid", WIN_VALID, 1);
      chk("f2_hold_x", WIN_X, 0);
      chk("f2_hold_y", WIN_Y, 0);
      chk("f2_hold_b0", WIN[7:0], mem[0]);
`ifdef SEQ_STALL_COUNT_EN
      chk("f2_stall10", STALL_CNT, 10);
`endif
      WIN_READY = 1'b1;
      rdy_mode = 1;
      wait_done(12000);
      rdy_mode = 0;
      tick();
      WIN_READY = 1'b1;

      // START pulsed while window (5,7) is presented must be ignored
      rand_mem();
      start_frame();
      for (c = 0; c < 3000; c++) begin
         tick();
         if (WIN_VALID && WIN_X == 5'd5 && WIN_Y == 5'd7) break;
      end
      chk("f3_reach_5_7", c < 3000, 1);
      START = 1'b1;
      tick();
      START = 1'b0;
      wait_done(6000);
      tick();
      chk("f3_idle_after_done", BUSY, 0);

      // reset mid row 10, then restart from (0,0)
      rand_mem();
      rdy_mode = 1;
      start_frame();
      for (c = 0; c < 20000; c++) begin
         tick();
         if (WIN_VALID && WIN_X == 5'd10) break;
      end
      chk("f4_reach_row10", c < 20000, 1);
      tick(); tick(); tick();
      nRST = 1'b0;
      #1;
      chk_zero("midreset");
      rdy_mode = 0;
      tick(); tick();
      WIN_READY = 1'b1;
      nRST = 1'b1;
      tick();
      start_frame();
      wait_done(6000);
      chk("f5_w00_cycle", win_rel[0], 27);
      chk("f5_rd_first", rd_first, 1);
      chk("f5_done_cycle", done_rel, 4513);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
